// File: rtl/traffic_light_pkg.sv
// Shared aspect encoding for the intersection controller and the per-approach lamp drivers.
// The controller builds its three-approach word from aspect_t so both sides agree on codes.
package traffic_pkg;

   typedef logic [1:0] aspect_t;

   localparam aspect_t ASP_RED    = 2'b00;
   localparam aspect_t ASP_YELLOW = 2'b01;
   localparam aspect_t ASP_GREEN  = 2'b10;
   localparam aspect_t ASP_FAULT  = 2'b11;

endpackage

// File: rtl/traffic_light_if.sv
// Aspect code in, lamp indications out, for one approach.
// No handshake: the controller presents a new code whenever it likes and it is sampled every edge.
interface traffic_light_if;
   import traffic_pkg::*;

   aspect_t state;
   logic    green;
   logic    yellow;
   logic    red;
   logic    fault;

   modport master (output state, input green, yellow, red, fault);
   modport slave  (input state, output green, yellow, red, fault);

endinterface

// File: rtl/traffic_light_blink_divider.sv
// Square-wave phase generator for the fault-flash red: BLINK_HALF cycles high, BLINK_HALF low.
// restart forces the start of a fresh on-interval and wins over enable.
module blink_divider #(
   parameter int BLINK_HALF = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic phase
);

   localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (restart) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (enable) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/traffic_light.sv
// Per-approach lamp driver: registered aspect decode plus fault-flash red.
// Reset and fault both show red; fault red flashes with BLINK_HALF-cycle half-period.
module traffic_light #(
   parameter int BLINK_HALF = 25_000_000
) (
   input  logic             clk,
   input  logic             reset,
   traffic_light_if.slave   lamp_if
);
   import traffic_pkg::*;

   aspect_t asp;
   logic    green_q, green_d;
   logic    yellow_q, yellow_d;
   logic    steady_red_q, steady_red_d;
   logic    fault_q, fault_d;
   logic    blink_restart, blink_enable, blink_phase;

   assign asp = lamp_if.state;

   always_comb begin
      green_d      = 1'b0;
      yellow_d     = 1'b0;
      steady_red_d = 1'b0;
      fault_d      = 1'b0;
      case (asp)
         ASP_RED:    steady_red_d = 1'b1;
         ASP_YELLOW: yellow_d     = 1'b1;
         ASP_GREEN:  green_d      = 1'b1;
         ASP_FAULT:  fault_d      = 1'b1;
      endcase
   end

   // fault_q remembers whether the previous edge was already in fault, so the
   // first fault edge restarts the flash and later ones advance it.
   assign blink_restart = (asp == ASP_FAULT) && !fault_q;
   assign blink_enable  = (asp == ASP_FAULT) &&  fault_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         green_q      <= 1'b0;
         yellow_q     <= 1'b0;
         steady_red_q <= 1'b1;
         fault_q      <= 1'b0;
      end else begin
         green_q      <= green_d;
         yellow_q     <= yellow_d;
         steady_red_q <= steady_red_d;
         fault_q      <= fault_d;
      end
   end

   blink_divider #(.BLINK_HALF(BLINK_HALF)) u_blink (
      .clk     (clk),
      .reset   (reset),
      .restart (blink_restart),
      .enable  (blink_enable),
      .phase   (blink_phase)
   );

   // Both mux inputs are flops, so red still only moves on a clock edge or reset.
   assign lamp_if.green  = green_q;
   assign lamp_if.yellow = yellow_q;
   assign lamp_if.red    = fault_q ? blink_phase : steady_red_q;
   assign lamp_if.fault  = fault_q;

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: one instance with BLINK_HALF=4 and one with BLINK_HALF=1,
// both fed the same aspect code.
module tb_traffic_light;
   import traffic_pkg::*;

   // Lamp vectors packed as {green, yellow, red, fault}
   localparam logic [3:0] V_RED = 4'b0010;
   localparam logic [3:0] V_YEL = 4'b0100;
   localparam logic [3:0] V_GRN = 4'b1000;
   localparam logic [3:0] V_FR1 = 4'b0011;
   localparam logic [3:0] V_FR0 = 4'b0001;

   logic    clk = 1'b0;
   logic    reset;
   aspect_t st;
   int      tests_run = 0;
   int      tests_failed = 0;

   always #5 clk = ~clk;

   traffic_light_if if4 ();
   traffic_light_if if1 ();

   assign if4.state = st;
   assign if1.state = st;

   traffic_light #(.BLINK_HALF(4)) dut4 (
      .clk     (clk),
      .reset   (reset),
      .lamp_if (if4.slave)
   );

   traffic_light #(.BLINK_HALF(1)) dut1 (
      .clk     (clk),
      .reset   (reset),
      .lamp_if (if1.slave)
   );

   wire [3:0] out4 = {if4.green, if4.yellow, if4.red, if4.fault};
   wire [3:0] out1 = {if1.green, if1.yellow, if1.red, if1.fault};

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_onehot(input string tag, input logic [3:0] v);
      logic [3:0] ok;
      ok = ($countones(v[3:1]) <= 1) ? 4'd1 : 4'd0;
      check(tag, ok, 4'd1);
   endtask

   // Present a code at the falling edge, then sample just after the next rising edge.
   task automatic step(input aspect_t a);
      @(negedge clk);
      st = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] flash_pat;
      logic [5:0]  exit_pat;
      logic [4:0]  reentry_pat;
      logic [5:0]  toggle_pat;
      aspect_t     sweep_codes [4];
      logic [3:0]  sweep_exp [4];
      logic [3:0]  prev;

      flash_pat   = 20'b1111_0000_1111_0000_1111;
      exit_pat    = 6'b1111_00;
      reentry_pat = 5'b1111_0;
      toggle_pat  = 6'b101010;
      sweep_codes = '{ASP_RED, ASP_YELLOW, ASP_GREEN, ASP_RED};
      sweep_exp   = '{V_RED, V_YEL, V_GRN, V_RED};

      // Reset behaviour
      reset = 1'b1;
      st    = ASP_GREEN;
      #1;
      check("reset_init", out4, V_RED);
      check("reset_init_bh1", out1, V_RED);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("reset_release_green", out4, V_GRN);
      #2;
      reset = 1'b1;
      #1;
      check("reset_async_mid_cycle", out4, V_RED);
      @(posedge clk);
      #1;
      check("reset_held_over_edge", out4, V_RED);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("reset_release_green2", out4, V_GRN);

      // Aspect sweep with one-cycle latency
      prev = V_GRN;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         st = sweep_codes[i];
         #1;
         check("sweep_before_edge", out4, prev);
         @(posedge clk);
         #1;
         check("sweep_after_edge", out4, sweep_exp[i]);
         check_onehot("sweep_onehot", out4);
         prev = sweep_exp[i];
      end

      // Fault flash, BLINK_HALF=4
      for (int i = 0; i < 20; i++) begin
         step(ASP_FAULT);
         check("flash", out4, flash_pat[19-i] ? V_FR1 : V_FR0);
         check_onehot("flash_onehot", out4);
      end

      // Fault exit and re-entry
      step(ASP_RED);
      check("exit_prep_red", out4, V_RED);
      for (int i = 0; i < 6; i++) begin
         step(ASP_FAULT);
         check("exit_flash", out4, exit_pat[5-i] ? V_FR1 : V_FR0);
      end
      for (int i = 0; i < 2; i++) begin
         step(ASP_GREEN);
         check("exit_green", out4, V_GRN);
         check_onehot("exit_onehot", out4);
      end
      for (int i = 0; i < 5; i++) begin
         step(ASP_FAULT);
         check("reentry_flash", out4, reentry_pat[4-i] ? V_FR1 : V_FR0);
      end

      // Reset asserted mid-flash (red is off here), then re-entry starts fresh
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_mid_flash", out4, V_RED);
      reset = 1'b0;
      step(ASP_FAULT);
      check("post_reset_fault_entry", out4, V_FR1);

      // BLINK_HALF=1 boundary
      step(ASP_YELLOW);
      check("bh1_prep_yellow", out1, V_YEL);
      for (int i = 0; i < 6; i++) begin
         step(ASP_FAULT);
         check("bh1_toggle", out1, toggle_pat[5-i] ? V_FR1 : V_FR0);
      end

      // Direct green to red, no yellow inserted
      step(ASP_GREEN);
      check("direct_green", out4, V_GRN);
      step(ASP_RED);
      check("direct_red", out4, V_RED);
      check("direct_red_bh1", out1, V_RED);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
